// File: rtl/quiz_judge_pkg.sv
// Shared types and helpers for the quiz judge: FSM state encoding, field
// widths and the contestant-count clamp used when the config is latched.
package quiz_judge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_ARMED = 2'd2,
      ST_JUDGE = 2'd3
   } quiz_state_t;

   localparam int TIME_W   = 8;
   localparam int USER_W   = 4;
   localparam int POINT_W  = 4;

   // A requested user count of 0, or one beyond what is built, means "use them all".
   function automatic logic [USER_W-1:0] clamp_users(input logic [USER_W-1:0] req,
                                                     input logic [USER_W-1:0] max_users);
      logic [USER_W-1:0] res;
      if (req == '0 || req > max_users) begin
         res = max_users;
      end else begin
         res = req;
      end
      return res;
   endfunction

endpackage

// File: rtl/quiz_judge_if.sv
// Host/contestant bus of the quiz judge: setting-block config, host pulses,
// contestant buttons in; FSM state, winner, countdown and scores out.
interface quiz_judge_if #(
   parameter int MAX_USERS = 8,
   parameter int SCORE_W   = 8
);
   logic                          endset;
   logic [7:0]                    maxtime;
   logic [3:0]                    maxuser;
   logic [3:0]                    scorejia;
   logic [3:0]                    scorejian;
   logic                          start;
   logic [MAX_USERS-1:0]          buzz;
   logic                          right;
   logic                          wrong;
   logic [1:0]                    state;
   logic [3:0]                    winner;
   logic [7:0]                    time_left;
   logic                          timeout;
   logic                          foul;
   logic [MAX_USERS*SCORE_W-1:0]  scores;

   modport master (
      output endset, maxtime, maxuser, scorejia, scorejian, start, buzz, right, wrong,
      input  state, winner, time_left, timeout, foul, scores
   );

   modport slave (
      input  endset, maxtime, maxuser, scorejia, scorejian, start, buzz, right, wrong,
      output state, winner, time_left, timeout, foul, scores
   );
endinterface

// File: rtl/quiz_judge_countdown.sv
// Answer-window timer: a prescaler turns clk into seconds and a seconds
// counter runs down from the loaded window length. A loaded value of 0 never
// expires, which gives the unlimited-time mode.
module quiz_countdown #(
   parameter int TICK_DIV = 100_000_000,
   parameter int TIME_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              run,
   input  logic [TIME_W-1:0] load_value,
   output logic [TIME_W-1:0] time_left,
   output logic              expire
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] prescale;
   logic             wrap;

   // expire says "this edge would take the counter to zero"; the caller decides whether it is running.
   assign wrap   = (prescale == PRE_LAST);
   assign expire = wrap && (time_left == TIME_W'(1));

   // Prescaler and seconds counter; load restarts a full second so the first step is a whole second long.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prescale  <= '0;
         time_left <= '0;
      end else if (load) begin
         prescale  <= '0;
         time_left <= load_value;
      end else if (run) begin
         if (wrap) begin
            prescale <= '0;
            if (time_left != '0) begin
               time_left <= time_left - TIME_W'(1);
            end
         end else begin
            prescale <= prescale + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/quiz_judge.sv
// Quiz judge top: latches the contest config, arms rounds, arbitrates the
// first buzz among active users, flags early buzzes as fouls and applies the
// host's right/wrong judgement to saturating per-user scores.
module quiz_judge
   import quiz_judge_pkg::*;
#(
   parameter int MAX_USERS = 8,
   parameter int SCORE_W   = 8,
   parameter int TICK_DIV  = 100_000_000
) (
   input  logic         clk,
   input  logic         rst,
   quiz_judge_if.slave  bus
);

   quiz_state_t           state_r;
   quiz_state_t           state_n;

   logic                  endset_q;
   logic [MAX_USERS-1:0]  buzz_q;
   logic [TIME_W-1:0]     maxtime_cfg;
   logic [USER_W-1:0]     maxuser_cfg;
   logic [POINT_W-1:0]    jia_cfg;
   logic [POINT_W-1:0]    jian_cfg;

   logic [USER_W-1:0]     winner_r;
   logic                  timeout_r;
   logic                  foul_r;
   logic [SCORE_W-1:0]    score_r [MAX_USERS];

   logic [MAX_USERS-1:0]  user_mask;
   logic [MAX_USERS-1:0]  buzz_edge;
   logic                  any_edge;
   logic                  endset_rise;
   logic [USER_W-1:0]     first_idx;

   logic                  latch_cfg;
   logic                  load_timer;
   logic                  run_timer;
   logic                  set_winner;
   logic                  clear_winner;
   logic                  foul_n;
   logic                  timeout_n;
   logic                  apply_right;
   logic                  apply_wrong;

   logic [TIME_W-1:0]     time_left;
   logic                  expire;

   // Clamp the score at full scale instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [POINT_W-1:0] b);
      logic [SCORE_W:0] s;
      s = (SCORE_W+1)'(a) + (SCORE_W+1)'(b);
      return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
   endfunction

   // Floor the score at zero instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a,
                                                  input logic [POINT_W-1:0] b);
      logic [SCORE_W-1:0] bw;
      bw = SCORE_W'(b);
      return (a < bw) ? '0 : (a - bw);
   endfunction

   assign endset_rise = bus.endset & ~endset_q;
   assign buzz_edge   = bus.buzz & ~buzz_q & user_mask;
   assign any_edge    = |buzz_edge;

   // Only the first maxuser_cfg buttons belong to contestants in this contest.
   always_comb begin
      user_mask = '0;
      for (int i = 0; i < MAX_USERS; i++) begin
         user_mask[i] = (USER_W'(i) < maxuser_cfg);
      end
   end

   // Priority encoder: scanning downward lets the lowest pressed index win a tie.
   always_comb begin
      first_idx = '0;
      for (int i = MAX_USERS - 1; i >= 0; i--) begin
         if (buzz_edge[i]) begin
            first_idx = USER_W'(i);
         end
      end
   end

   quiz_countdown #(
      .TICK_DIV (TICK_DIV),
      .TIME_W   (TIME_W)
   ) u_countdown (
      .clk        (clk),
      .rst        (rst),
      .load       (load_timer),
      .run        (run_timer),
      .load_value (maxtime_cfg),
      .time_left  (time_left),
      .expire     (expire)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic: a buzz in ARMED beats a same-cycle expiry; a double judgement is ignored.
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE:  if (endset_rise)             state_n = ST_READY;
         ST_READY: if (bus.start)               state_n = ST_ARMED;
         ST_ARMED: begin
            if (any_edge)                       state_n = ST_JUDGE;
            else if (expire)                    state_n = ST_READY;
         end
         ST_JUDGE: if (bus.right ^ bus.wrong)   state_n = ST_READY;
         default:                               state_n = ST_IDLE;
      endcase
   end

   // Per-state control strobes for the config, timer, winner, pulse and score datapath.
   always_comb begin
      latch_cfg    = 1'b0;
      load_timer   = 1'b0;
      run_timer    = 1'b0;
      set_winner   = 1'b0;
      clear_winner = 1'b0;
      foul_n       = 1'b0;
      timeout_n    = 1'b0;
      apply_right  = 1'b0;
      apply_wrong  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            latch_cfg = endset_rise;
         end
         ST_READY: begin
            latch_cfg = endset_rise;
            if (bus.start) begin
               load_timer   = 1'b1;
               clear_winner = 1'b1;
            end else if (any_edge) begin
               foul_n = 1'b1;
            end
         end
         ST_ARMED: begin
            if (any_edge) begin
               set_winner = 1'b1;
            end else begin
               run_timer = 1'b1;
               timeout_n = expire;
            end
         end
         ST_JUDGE: begin
            apply_right = bus.right & ~bus.wrong;
            apply_wrong = bus.wrong & ~bus.right;
         end
         default: ;
      endcase
   end

   // Datapath registers: input history, config, winner, one-cycle pulses and scores.
   always_ff @(posedge clk) begin
      if (!rst) begin
         endset_q    <= 1'b0;
         buzz_q      <= '0;
         maxtime_cfg <= '0;
         maxuser_cfg <= '0;
         jia_cfg     <= '0;
         jian_cfg    <= '0;
         winner_r    <= '0;
         timeout_r   <= 1'b0;
         foul_r      <= 1'b0;
         for (int i = 0; i < MAX_USERS; i++) begin
            score_r[i] <= '0;
         end
      end else begin
         endset_q  <= bus.endset;
         buzz_q    <= bus.buzz;
         timeout_r <= timeout_n;
         foul_r    <= foul_n;
         if (latch_cfg) begin
            maxtime_cfg <= bus.maxtime;
            maxuser_cfg <= clamp_users(bus.maxuser, USER_W'(MAX_USERS));
            jia_cfg     <= bus.scorejia;
            jian_cfg    <= bus.scorejian;
         end
         if (clear_winner) begin
            winner_r <= '0;
         end else if (set_winner) begin
            winner_r <= first_idx + USER_W'(1);
         end
         for (int i = 0; i < MAX_USERS; i++) begin
            if (USER_W'(i + 1) == winner_r) begin
               if (apply_right) begin
                  score_r[i] <= sat_add(score_r[i], jia_cfg);
               end else if (apply_wrong) begin
                  score_r[i] <= sat_sub(score_r[i], jian_cfg);
               end
            end
         end
      end
   end

   assign bus.state     = state_r;
   assign bus.winner    = winner_r;
   assign bus.time_left = time_left;
   assign bus.timeout   = timeout_r;
   assign bus.foul      = foul_r;

   for (genvar g = 0; g < MAX_USERS; g++) begin : g_scores
      assign bus.scores[g*SCORE_W +: SCORE_W] = score_r[g];
   end

endmodule
